// File: rtl/ysyx_24100005_mem_responder_if.sv
// Load/store port bundle between the core LSU (master) and the memory responder (slave).
// Request channel:  req_valid/req_ready handshake carrying req_wen, req_addr, req_wdata and
//                   req_wmask.
// Response channel: resp_valid/resp_ready handshake carrying resp_rdata and resp_err.
interface ysyx_24100005_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/ysyx_24100005_mem_responder.sv
// Word-organised memory responder for the core load/store port. Accepts one read or write
// per request handshake, applies it to internal storage and answers after LATENCY cycles.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - asynchronous active-low reset
//   bus  - slave side of the request/response bundle
// Parameters:
//   DEPTH   - number of 32-bit words (power of two, at least 2)
//   BASE    - byte address of word 0
//   LATENCY - cycles from request acceptance to resp_valid (1..15)
module ysyx_24100005_mem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned LATENCY = 1
) (
   input logic                          clk,
   input logic                          rst,
   ysyx_24100005_mem_responder_if.slave bus
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam logic [31:0] SPAN   = 32'(DEPTH * 4);
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;
   logic [31:0]      mem [DEPTH];
   logic [31:0]      offset;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic             mem_we;
   logic             unused_mask;

   // Unsigned subtract makes addresses below BASE wrap to huge offsets, so one compare
   // covers both ends of the window.
   assign offset   = bus.req_addr - BASE;
   assign in_range = offset < SPAN;
   assign idx      = offset[IDX_W+1:2];
   assign accept   = (state_q == IDLE) && bus.req_valid;
   assign mem_we   = accept && bus.req_wen && in_range;

   assign unused_mask = ^bus.req_wmask[7:4];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (!in_range) begin
                  rdata_d = 32'h0;
                  err_d   = 1'b1;
               end else if (!bus.req_wen) begin
                  rdata_d = mem[idx];
                  err_d   = 1'b0;
               end else begin
                  rdata_d = 32'h0;
                  err_d   = 1'b0;
               end
               if (LATENCY <= 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
               rdata_d = 32'h0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            rdata_d = 32'h0;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage keeps its contents through reset; reset only blocks a write in that cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
      end else if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.req_wmask[i]) begin
               mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
         end
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_responder.sv
// Self-checking bench for ysyx_24100005_mem_responder. Four instances with LATENCY 1, 3, 4
// and 2 share the stimulus; sel picks which one is driven and observed.
module tb_ysyx_24100005_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sel;
   logic        req_valid, req_wen, resp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [7:0]  req_wmask;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [3:0]  rdy_v, vld_v, err_v;
   logic [31:0] rdata_a [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      ysyx_24100005_mem_responder_if bus ();
      assign bus.req_valid  = req_valid && (sel == 2'(g));
      assign bus.resp_ready = resp_ready && (sel == 2'(g));
      assign bus.req_wen    = req_wen;
      assign bus.req_addr   = req_addr;
      assign bus.req_wdata  = req_wdata;
      assign bus.req_wmask  = req_wmask;
      assign rdy_v[g]       = bus.req_ready;
      assign vld_v[g]       = bus.resp_valid;
      assign err_v[g]       = bus.resp_err;
      assign rdata_a[g]     = bus.resp_rdata;
      ysyx_24100005_mem_responder #(
         .LATENCY((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 2)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );
   end

   always_comb begin
      req_ready  = rdy_v[sel];
      resp_valid = vld_v[sel];
      resp_err   = err_v[sel];
      resp_rdata = rdata_a[sel];
   end

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  mask;
      logic [31:0] erd;
      logic        eerr;
   } vec_t;

   resp_t sbq[$];
   int    errors = 0;
   int    checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request on the selected instance, response held for 'stall' cycles before consume.
   task automatic txn(input vec_t v, input int lat, input int stall, input string tag);
      int    n;
      resp_t exp;
      chk({tag, " req_ready before"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_wen    = v.wen;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_wmask  = v.mask;
      resp_ready = 1'b0;
      step();
      sbq.push_back('{rdata: v.erd, err: v.eerr});
      // Scramble the fields: they must not be re-sampled after acceptance.
      req_valid = 1'b0;
      req_wen   = ~v.wen;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wmask = 8'hFF;
      n = 0;
      while (!resp_valid && n < 40) begin
         step();
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(lat - 1));
      chk({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
      for (int s = 0; s < stall; s++) begin
         step();
         chk({tag, " stall valid"}, 32'(resp_valid), 32'd1);
         chk({tag, " stall rdata"}, resp_rdata, sbq[0].rdata);
         chk({tag, " stall err"}, 32'(resp_err), 32'(sbq[0].err));
         chk({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      exp = sbq.pop_front();
      chk({tag, " rdata"}, resp_rdata, exp.rdata);
      chk({tag, " err"}, 32'(resp_err), 32'(exp.err));
      step();
      resp_ready = 1'b0;
      chk({tag, " valid after"}, 32'(resp_valid), 32'd0);
      chk({tag, " req_ready after"}, 32'(req_ready), 32'd1);
      chk({tag, " rdata cleared"}, resp_rdata, 32'h0);
      chk({tag, " err cleared"}, 32'(resp_err), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vec_t  vt [14];
      vec_t  bb [5];
      vec_t  v;
      resp_t exp;
      int    k, cyc, last_acc;

      vt = '{
         '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0,         1'b0},
         '{1'b0, 32'h8000_0010, 32'h0,         8'h00, 32'hDEAD_BEEF, 1'b0},
         '{1'b1, 32'h8000_0012, 32'h0000_AB00, 8'h02, 32'h0,         1'b0},
         '{1'b0, 32'h8000_0010, 32'h0,         8'h00, 32'hDEAD_ABEF, 1'b0},
         '{1'b1, 32'h8000_0000, 32'h1122_3344, 8'h0F, 32'h0,         1'b0},
         '{1'b0, 32'h7FFF_FFFC, 32'h0,         8'h00, 32'h0,         1'b1},
         '{1'b0, 32'h8000_1000, 32'h0,         8'h00, 32'h0,         1'b1},
         '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, 32'h0,         1'b1},
         '{1'b0, 32'h8000_0000, 32'h0,         8'h00, 32'h1122_3344, 1'b0},
         '{1'b1, 32'h8000_0000, 32'hAAAA_AAAA, 8'h00, 32'h0,         1'b0},
         '{1'b0, 32'h8000_0000, 32'h0,         8'h00, 32'h1122_3344, 1'b0},
         '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 8'hFF, 32'h0,         1'b0},
         '{1'b0, 32'h8000_0FFC, 32'h0,         8'h00, 32'hCAFE_F00D, 1'b0},
         '{1'b1, 32'h8000_0000, 32'h0000_5500, 8'hF2, 32'h0,         1'b0}
      };
      bb = '{
         '{1'b1, 32'h8000_0080, 32'hA1A1_A1A1, 8'h0F, 32'h0,         1'b0},
         '{1'b1, 32'h8000_0084, 32'hB2B2_B2B2, 8'h0F, 32'h0,         1'b0},
         '{1'b0, 32'h8000_0080, 32'h0,         8'h00, 32'hA1A1_A1A1, 1'b0},
         '{1'b0, 32'h8000_0084, 32'h0,         8'h00, 32'hB2B2_B2B2, 1'b0},
         '{1'b0, 32'h9000_0000, 32'h0,         8'h00, 32'h0,         1'b1}
      };

      rst        = 1'b0;
      sel        = 2'd0;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_wmask  = 8'h0;
      resp_ready = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         #1;
         chk($sformatf("reset req_ready%0d", i), 32'(req_ready), 32'd1);
         chk($sformatf("reset resp_valid%0d", i), 32'(resp_valid), 32'd0);
         chk($sformatf("reset rdata%0d", i), resp_rdata, 32'h0);
         chk($sformatf("reset err%0d", i), 32'(resp_err), 32'd0);
      end
      rst = 1'b1;
      step();

      // Table vectors at LATENCY=1.
      sel = 2'd0;
      for (int i = 0; i < 14; i++) txn(vt[i], 1, 0, $sformatf("vec%0d", i));
      v = '{1'b0, 32'h8000_0000, 32'h0, 8'h00, 32'h1122_5544, 1'b0};
      txn(v, 1, 0, "lane1 upper mask ignored");

      // LATENCY=3 with a stalled consumer.
      sel = 2'd1;
      v = '{1'b1, 32'h8000_0020, 32'h1234_5678, 8'h0F, 32'h0, 1'b0};
      txn(v, 3, 0, "l3 write");
      v = '{1'b0, 32'h8000_0020, 32'h0, 8'h00, 32'h1234_5678, 1'b0};
      txn(v, 3, 4, "l3 read stall");
      v = '{1'b0, 32'h8000_1000, 32'h0, 8'h00, 32'h0, 1'b1};
      txn(v, 3, 2, "l3 err stall");

      // LATENCY=4: reset two cycles into WAIT; write still lands.
      sel = 2'd2;
      v = '{1'b1, 32'h8000_0040, 32'h0BAD_CAFE, 8'h0F, 32'h0, 1'b0};
      txn(v, 4, 0, "l4 write");
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = 32'h8000_0044;
      req_wdata = 32'h600D_F00D;
      req_wmask = 8'h0F;
      step();
      req_valid = 1'b0;
      step();
      step();
      chk("mid-wait req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("async rst resp_valid", 32'(resp_valid), 32'd0);
      chk("async rst req_ready", 32'(req_ready), 32'd1);
      chk("async rst rdata", resp_rdata, 32'h0);
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("no resp after rst", 32'(resp_valid), 32'd0);
      end
      v = '{1'b0, 32'h8000_0044, 32'h0, 8'h00, 32'h600D_F00D, 1'b0};
      txn(v, 4, 0, "l4 read committed");
      v = '{1'b0, 32'h8000_0040, 32'h0, 8'h00, 32'h0BAD_CAFE, 1'b0};
      txn(v, 4, 0, "l4 read earlier");

      // LATENCY=2 back-to-back with req_valid and resp_ready held high.
      sel        = 2'd3;
      resp_ready = 1'b1;
      k          = 0;
      cyc        = 0;
      last_acc   = -1;
      while ((k < 5 || sbq.size() != 0) && cyc < 100) begin
         if (k < 5) begin
            req_valid = 1'b1;
            req_wen   = bb[k].wen;
            req_addr  = bb[k].addr;
            req_wdata = bb[k].wdata;
            req_wmask = bb[k].mask;
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (req_ready && req_valid) begin
            if (last_acc >= 0) chk("b2b spacing", 32'(cyc - last_acc), 32'd3);
            last_acc = cyc;
            sbq.push_back('{rdata: bb[k].erd, err: bb[k].eerr});
            k++;
         end
         if (resp_valid) begin
            if (sbq.size() == 0) begin
               chk("b2b unexpected resp", 32'(resp_valid), 32'd0);
            end else begin
               exp = sbq.pop_front();
               chk("b2b rdata", resp_rdata, exp.rdata);
               chk("b2b err", 32'(resp_err), 32'(exp.err));
            end
         end
         step();
         cyc++;
      end
      chk("b2b issued", 32'(k), 32'd5);
      chk("b2b drained", 32'(sbq.size()), 32'd0);
      req_valid  = 1'b0;
      resp_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
